// File: rtl/heptagon_pkg.sv
// Shared constants and types for the heptagon area sorting controller.
package heptagon_pkg;

    localparam int NUM_VERT = 7;    // vertices per object
    localparam int NUM_OBJ  = 5;    // objects per batch
    localparam int IDX_W    = 3;    // object index / rank address width
    localparam int X_W      = 10;   // datapath X coordinate width
    localparam int Y_W      = 10;   // datapath Y coordinate width
    localparam int AREA_W   = 19;   // datapath area width

    // Controller sequencing states, in batch order.
    typedef enum logic [2:0] {
        LOAD,
        SORT,
        WAIT,
        OUT,
        DONE
    } ctrl_state_t;

endpackage : heptagon_pkg

// File: rtl/heptagon_pt_cnt.sv
// Vertex/object counter pair tracking the fixed coordinate stream position.
module heptagon_pt_cnt
    import heptagon_pkg::*;
#(
    parameter int P_NUM_VERT = NUM_VERT,
    parameter int P_NUM_OBJ  = NUM_OBJ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_vcnt,
    output logic [IDX_W-1:0] o_ocnt,
    output logic             o_last_vert,
    output logic             o_last_obj
);

    localparam logic [IDX_W-1:0] V_LAST = IDX_W'(P_NUM_VERT - 1);
    localparam logic [IDX_W-1:0] O_LAST = IDX_W'(P_NUM_OBJ);

    logic [IDX_W-1:0] r_vcnt;
    logic [IDX_W-1:0] r_ocnt;
    logic             w_last_vert;
    logic             w_last_obj;

    assign w_last_vert = (r_vcnt == V_LAST);
    assign w_last_obj  = (r_ocnt == O_LAST);

    // Advance one vertex per enabled cycle; the vertex wrap steps the object.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vcnt <= '0;
            r_ocnt <= IDX_W'(1);
        end else if (i_en) begin
            if (w_last_vert) begin
                r_vcnt <= '0;
                // Object count holds at the last object once the batch is in.
                if (!w_last_obj) begin
                    r_ocnt <= r_ocnt + IDX_W'(1);
                end
            end else begin
                r_vcnt <= r_vcnt + IDX_W'(1);
            end
        end
    end

    assign o_vcnt      = r_vcnt;
    assign o_ocnt      = r_ocnt;
    assign o_last_vert = w_last_vert;
    assign o_last_obj  = w_last_obj;

endmodule : heptagon_pt_cnt

// File: rtl/heptagon_ctrl.sv
// Sequencing controller: drives shoelace datapath strobes over the vertex
// stream, kicks the sorter, then reads out the ranked results once.
module heptagon_ctrl #(
    parameter int NUM_VERT = heptagon_pkg::NUM_VERT,
    parameter int NUM_OBJ  = heptagon_pkg::NUM_OBJ
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          vert_first,
    output logic                          mac_en,
    output logic                          close_en,
    output logic                          area_wr,
    output logic [heptagon_pkg::IDX_W-1:0] obj_idx,
    output logic                          sort_start,
    input  logic                          sort_done,
    output logic                          rd_en,
    output logic [heptagon_pkg::IDX_W-1:0] rd_addr,
    output logic                          valid,
    output logic                          busy
);

    import heptagon_pkg::*;

    localparam logic [IDX_W-1:0] RANK_LAST = IDX_W'(NUM_OBJ - 1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [IDX_W-1:0] r_rd_addr;
    logic             r_valid;

    logic [IDX_W-1:0] w_vcnt;
    logic [IDX_W-1:0] w_ocnt;
    logic             w_last_vert;
    logic             w_last_obj;
    logic             w_cnt_en;
    logic             w_rd_en;

    // Counters only run while the coordinate stream is being consumed.
    assign w_cnt_en = (r_state == LOAD);

    heptagon_pt_cnt #(
        .P_NUM_VERT (NUM_VERT),
        .P_NUM_OBJ  (NUM_OBJ)
    ) u_pt_cnt (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_cnt_en),
        .o_vcnt      (w_vcnt),
        .o_ocnt      (w_ocnt),
        .o_last_vert (w_last_vert),
        .o_last_obj  (w_last_obj)
    );

    // State register; reset is also the batch-restart mechanism.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; sort_done is only looked at while waiting.
    // NOTE: next state defaults to the current state so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD: if (w_last_vert && w_last_obj) w_next_state = SORT;
            SORT: w_next_state = WAIT;
            WAIT: if (sort_done) w_next_state = OUT;
            OUT:  if (r_rd_addr == RANK_LAST) w_next_state = DONE;
            DONE: w_next_state = DONE;
            default: w_next_state = LOAD;
        endcase
    end

    // Rank read address steps once per OUT cycle and rewinds after the last rank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_addr <= '0;
        end else if (r_state == OUT) begin
            r_rd_addr <= (r_rd_addr == RANK_LAST) ? '0 : r_rd_addr + IDX_W'(1);
        end
    end

    // Output qualifier tracks the one-cycle sorter read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_en;
        end
    end

    // Strobe decode purely from registered state and counters.
    always_comb begin
        vert_first = 1'b0;
        mac_en     = 1'b0;
        close_en   = 1'b0;
        area_wr    = 1'b0;
        obj_idx    = '0;
        sort_start = 1'b0;
        w_rd_en    = 1'b0;
        rd_addr    = '0;
        busy       = 1'b1;
        case (r_state)
            LOAD: begin
                vert_first = (w_vcnt == '0);
                mac_en     = (w_vcnt != '0);
                close_en   = w_last_vert;
                area_wr    = w_last_vert;
                obj_idx    = w_ocnt;
            end
            SORT: sort_start = 1'b1;
            WAIT: ;
            OUT: begin
                w_rd_en = 1'b1;
                rd_addr = r_rd_addr;
            end
            DONE: busy = 1'b0;
            default: ;
        endcase
    end

    assign rd_en = w_rd_en;
    assign valid = r_valid;

endmodule : heptagon_ctrl

// File: tb/tb_heptagon_ctrl.sv
// Self-checking bench for heptagon_ctrl: a timeline model pushes the expected
// output vector for each cycle into a scoreboard, popped when outputs are sampled.
module tb_heptagon_ctrl;

    typedef struct packed {
        logic       vert_first;
        logic       mac_en;
        logic       close_en;
        logic       area_wr;
        logic [2:0] obj_idx;
        logic       sort_start;
        logic       rd_en;
        logic [2:0] rd_addr;
        logic       valid;
        logic       busy;
    } obs_t;

    localparam int SC_NOMINAL = 0;
    localparam int SC_DELAYED = 1;
    localparam int SC_EARLY   = 2;

    logic       clk;
    logic       reset;
    logic       vert_first, mac_en, close_en, area_wr;
    logic [2:0] obj_idx;
    logic       sort_start, sort_done, rd_en;
    logic [2:0] rd_addr;
    logic       valid, busy;

    obs_t obs;
    obs_t reset_vec;
    obs_t sb_q[$];
    int   n_checks;
    int   n_errors;
    int   n_valid;

    heptagon_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .vert_first (vert_first),
        .mac_en     (mac_en),
        .close_en   (close_en),
        .area_wr    (area_wr),
        .obj_idx    (obj_idx),
        .sort_start (sort_start),
        .sort_done  (sort_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .valid      (valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {vert_first, mac_en, close_en, area_wr, obj_idx,
                  sort_start, rd_en, rd_addr, valid, busy};

    // Expected outputs at cycle k when sort_done is first accepted at cycle n.
    function automatic obs_t model(int k, int n);
        obs_t e;
        int   v;
        e = '0;
        if (k <= 34) begin
            v            = k % 7;
            e.vert_first = (v == 0);
            e.mac_en     = (v != 0);
            e.close_en   = (v == 6);
            e.area_wr    = (v == 6);
            e.obj_idx    = 3'(k / 7 + 1);
            e.busy       = 1'b1;
        end else if (k == 35) begin
            e.sort_start = 1'b1;
            e.busy       = 1'b1;
        end else if (k <= n) begin
            e.busy = 1'b1;
        end else if (k <= n + 5) begin
            e.rd_en   = 1'b1;
            e.rd_addr = 3'(k - n - 1);
            e.valid   = (k >= n + 2);
            e.busy    = 1'b1;
        end else if (k == n + 6) begin
            e.valid = 1'b1;
        end
        return e;
    endfunction

    function automatic logic sd_drive(int scen, int k);
        case (scen)
            SC_NOMINAL: return 1'b1;
            SC_DELAYED: return (k == 60);
            default:    return ((k >= 30) && (k <= 35)) || (k >= 50);
        endcase
    endfunction

    function automatic int sd_accept(int scen);
        case (scen)
            SC_NOMINAL: return 36;
            SC_DELAYED: return 60;
            default:    return 50;
        endcase
    endfunction

    // Starts at the cycle-0 sample point (just after reset release).
    task automatic run_batch(input int scen, input int ncyc, input string name);
        obs_t exp_v;
        n_valid = 0;
        for (int k = 0; k < ncyc; k++) begin
            sort_done = sd_drive(scen, k);
            sb_q.push_back(model(k, sd_accept(scen)));
            #1;
            exp_v = sb_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs, exp_v);
            end
            if (valid === 1'b1) n_valid++;
            if (k < ncyc - 1) @(negedge clk);
        end
    endtask

    task automatic check_reset_vec(input string name);
        n_checks++;
        if (obs !== reset_vec) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, obs, reset_vec);
        end
    endtask

    // Hold reset across nhold edges, checking reset values, then release at a negedge.
    task automatic apply_reset(input int nhold, input string name);
        @(negedge clk);
        reset     = 1'b1;
        sort_done = 1'b0;
        repeat (nhold) begin
            @(negedge clk);
            check_reset_vec(name);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        sort_done = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vec("reset_values");
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        run_batch(SC_NOMINAL, 46, "nominal");
    endtask

    task automatic test_delayed();
        apply_reset(2, "delayed_reset");
        run_batch(SC_DELAYED, 70, "delayed");
        n_checks++;
        if (n_valid !== 5) begin
            n_errors++;
            $display("FAIL delayed_valid_count: got %0d expected 5", n_valid);
        end
    endtask

    task automatic test_early();
        apply_reset(1, "early_reset");
        run_batch(SC_EARLY, 60, "early");
    endtask

    task automatic test_mid_reset();
        apply_reset(1, "mid_pre_reset");
        run_batch(SC_NOMINAL, 18, "mid_prefix");
        #2;
        reset = 1'b1;
        #1;
        check_reset_vec("mid_async_clear");
        repeat (2) begin
            @(negedge clk);
            check_reset_vec("mid_reset_hold");
        end
        reset = 1'b0;
        run_batch(SC_NOMINAL, 46, "mid_restart");
    endtask

    task automatic test_back_to_back();
        apply_reset(2, "b2b_reset_1");
        run_batch(SC_NOMINAL, 46, "b2b_first");
        apply_reset(2, "b2b_reset_2");
        run_batch(SC_NOMINAL, 46, "b2b_second");
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_vec = '0;
        reset_vec.vert_first = 1'b1;
        reset_vec.obj_idx    = 3'd1;
        reset_vec.busy       = 1'b1;
        test_reset();
        test_nominal();
        test_delayed();
        test_early();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_heptagon_ctrl
